// File: rtl/axi_pkg.sv
// axi_pkg: handshake state encodings, burst types and response codes shared
// by the AXI read and write protocol FSMs.
package axi_pkg;
    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_COMMIT = 2'b01,
        ST_ASSERT = 2'b10
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    endfunction
endpackage

// File: rtl/axi_read_protocol_if.sv
// axi_read_protocol_if: request/slave inputs and registered AR/R outputs of
// the read protocol model; slave modport is the model, master drives it.
interface axi_read_protocol_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0] araddr_in;
    logic [7:0]    arlen_in;
    logic [2:0]    arsize_in;
    logic [1:0]    arburst_in;
    logic          arvalid_in;
    logic [DW-1:0] rdata_in;
    logic          rvalid_in;
    logic          rready_in;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [AW-1:0] beat_addr;

    modport slave (
        input  araddr_in, arlen_in, arsize_in, arburst_in, arvalid_in,
               rdata_in, rvalid_in, rready_in,
        output axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
               axi_rready, beat_addr
    );

    modport master (
        output araddr_in, arlen_in, arsize_in, arburst_in, arvalid_in,
               rdata_in, rvalid_in, rready_in,
        input  axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
               axi_rready, beat_addr
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP
// bursts; the reserved burst type 2'b11 advances like INCR.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_addr,
    input  logic [2:0]    i_size,
    input  logic [7:0]    i_len,
    input  logic [1:0]    i_burst,
    output logic [AW-1:0] o_next
);
    logic [AW-1:0] w_bytes, w_span, w_base, w_incr;

    // Modulo rather than a mask keeps non power-of-two wrap spans aligned too.
    always_comb begin
        w_bytes = AW'(1) << i_size;
        w_span  = AW'({1'b0, i_len} + 9'd1) << i_size;
        w_base  = i_addr - (i_addr % w_span);
        w_incr  = i_addr + w_bytes;
        o_next  = i_burst == BURST_FIXED ? i_addr :
                  i_burst == BURST_WRAP  ? w_base + ((w_incr - w_base) % w_span) :
                  w_incr;
    end
endmodule

// File: rtl/axi_read_protocol.sv
// axi_read_protocol: single-outstanding AXI read reference model with AR and
// R channel WAIT/COMMIT/ASSERT FSMs. Build option: AXI_RD_SLVERR_EN.
module axi_read_protocol
    import axi_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic               axi_aclk,
    input  logic               axi_reset,
    axi_read_protocol_if.slave bus
);
    state_t        r_ar_state, w_ar_state, r_r_state, w_r_state;
    logic [AW-1:0] r_araddr, w_araddr, r_beat_addr, w_beat_addr, w_next_addr;
    logic [7:0]    r_arlen, w_arlen, r_b_len, w_b_len, r_beat_cnt, w_beat_cnt, w_cnt_dec;
    logic [2:0]    r_arsize, w_arsize, r_b_size, w_b_size;
    logic [1:0]    r_arburst, w_arburst, r_b_burst, w_b_burst;
    logic          r_arvalid, w_arvalid, r_arready, w_arready;
    logic [DW-1:0] r_rdata, w_rdata;
    logic          r_rlast, w_rlast, r_rvalid, w_rvalid, r_rready, w_rready;
    logic          r_active, w_active, w_load, w_load_last;
`ifdef AXI_RD_SLVERR_EN
    logic          r_err, w_err;
    logic [1:0]    r_rresp, w_rresp;
`endif

    // The active burst keeps its own len/size/burst so a queued request
    // latched into the AR registers cannot disturb its address sequence.
    axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
        .i_addr (r_beat_addr),
        .i_size (r_b_size),
        .i_len  (r_b_len),
        .i_burst(r_b_burst),
        .o_next (w_next_addr)
    );

    always_comb begin
        w_ar_state  = r_ar_state;
        w_r_state   = r_r_state;
        w_araddr    = r_araddr;
        w_arlen     = r_arlen;
        w_arsize    = r_arsize;
        w_arburst   = r_arburst;
        w_arvalid   = r_arvalid;
        w_arready   = r_arready;
        w_b_len     = r_b_len;
        w_b_size    = r_b_size;
        w_b_burst   = r_b_burst;
        w_beat_cnt  = r_beat_cnt;
        w_beat_addr = r_beat_addr;
        w_rdata     = r_rdata;
        w_rlast     = r_rlast;
        w_rvalid    = r_rvalid;
        w_rready    = r_rready;
        w_active    = r_active;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        w_cnt_dec   = r_beat_cnt - 8'd1;
`ifdef AXI_RD_SLVERR_EN
        w_err       = r_err;
        w_rresp     = r_rresp;
`endif
        case (r_ar_state)
            ST_WAIT: begin
                w_arready = !r_active;
                if (bus.arvalid_in) begin
                    w_araddr   = bus.araddr_in;
                    w_arlen    = bus.arlen_in;
                    w_arsize   = bus.arsize_in;
                    w_arburst  = bus.arburst_in;
                    w_arvalid  = 1'b1;
                    w_ar_state = r_active ? ST_ASSERT : ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_active    = 1'b1;
                w_beat_cnt  = r_arlen;
                w_beat_addr = r_araddr;
                w_b_len     = r_arlen;
                w_b_size    = r_arsize;
                w_b_burst   = r_arburst;
                w_arvalid   = 1'b0;
                w_arready   = 1'b0;
                w_ar_state  = ST_WAIT;
`ifdef AXI_RD_SLVERR_EN
                w_err = r_arburst == 2'b11 || (r_arburst == BURST_WRAP && !wrap_len_ok(r_arlen));
`endif
            end
            ST_ASSERT: begin
                if (!r_active) begin
                    w_arready  = 1'b1;
                    w_ar_state = ST_COMMIT;
                end
            end
            default: w_ar_state = ST_WAIT;
        endcase
        case (r_r_state)
            ST_WAIT: begin
                if (r_active && bus.rvalid_in) begin
                    w_load      = 1'b1;
                    w_load_last = r_beat_cnt == 8'd0;
                end else begin
                    w_rready = bus.rready_in;
                    w_rvalid = 1'b0;
                end
            end
            ST_COMMIT: begin
                w_beat_cnt  = w_cnt_dec;
                w_beat_addr = w_next_addr;
                if (r_rlast) begin
                    w_active  = 1'b0;
                    w_rvalid  = 1'b0;
                    w_rlast   = 1'b0;
                    w_rready  = 1'b0;
                    w_r_state = ST_WAIT;
                end else if (bus.rvalid_in) begin
                    w_load      = 1'b1;
                    w_load_last = w_cnt_dec == 8'd0;
                end else begin
                    w_rvalid  = 1'b0;
                    w_r_state = ST_WAIT;
                end
            end
            ST_ASSERT: begin
                if (bus.rready_in) begin
                    w_rready  = 1'b1;
                    w_r_state = ST_COMMIT;
                end
            end
            default: w_r_state = ST_WAIT;
        endcase
        // rlast of a freshly loaded beat reflects the count after any decrement this cycle.
        if (w_load) begin
            w_rdata   = bus.rdata_in;
            w_rvalid  = 1'b1;
            w_rlast   = w_load_last;
            w_rready  = bus.rready_in;
            w_r_state = bus.rready_in ? ST_COMMIT : ST_ASSERT;
`ifdef AXI_RD_SLVERR_EN
            w_rresp   = r_err ? RESP_SLVERR : RESP_OKAY;
`endif
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_ar_state  <= ST_WAIT;
            r_r_state   <= ST_WAIT;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arsize    <= '0;
            r_arburst   <= '0;
            r_arvalid   <= 1'b0;
            r_arready   <= 1'b1;
            r_b_len     <= '0;
            r_b_size    <= '0;
            r_b_burst   <= '0;
            r_beat_cnt  <= '0;
            r_beat_addr <= '0;
            r_rdata     <= '0;
            r_rlast     <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rready    <= 1'b0;
            r_active    <= 1'b0;
`ifdef AXI_RD_SLVERR_EN
            r_err       <= 1'b0;
            r_rresp     <= RESP_OKAY;
`endif
        end else begin
            r_ar_state  <= w_ar_state;
            r_r_state   <= w_r_state;
            r_araddr    <= w_araddr;
            r_arlen     <= w_arlen;
            r_arsize    <= w_arsize;
            r_arburst   <= w_arburst;
            r_arvalid   <= w_arvalid;
            r_arready   <= w_arready;
            r_b_len     <= w_b_len;
            r_b_size    <= w_b_size;
            r_b_burst   <= w_b_burst;
            r_beat_cnt  <= w_beat_cnt;
            r_beat_addr <= w_beat_addr;
            r_rdata     <= w_rdata;
            r_rlast     <= w_rlast;
            r_rvalid    <= w_rvalid;
            r_rready    <= w_rready;
            r_active    <= w_active;
`ifdef AXI_RD_SLVERR_EN
            r_err       <= w_err;
            r_rresp     <= w_rresp;
`endif
        end
    end

    assign bus.axi_araddr  = r_araddr;
    assign bus.axi_arlen   = r_arlen;
    assign bus.axi_arsize  = r_arsize;
    assign bus.axi_arburst = r_arburst;
    assign bus.axi_arvalid = r_arvalid;
    assign bus.axi_arready = r_arready;
    assign bus.axi_rdata   = r_rdata;
    assign bus.axi_rlast   = r_rlast;
    assign bus.axi_rvalid  = r_rvalid;
    assign bus.axi_rready  = r_rready;
    assign bus.beat_addr   = r_beat_addr;
`ifdef AXI_RD_SLVERR_EN
    assign bus.axi_rresp   = r_rresp;
`else
    assign bus.axi_rresp   = RESP_OKAY;
`endif
endmodule
